uart_link_ctl: RTL and testbench

//  Protocol controller sequencing the byte-UART link between the two game boards.
//  - Sends START when the local player clicks PLAY.
//  - Raises uart_start once both boards are ready; this feeds state_machine.
//  - Exchanges final scores at game end and presents op_score to the score path.
//  - Sits between rect_clicked_play/score_counter and the UART tx/rx core, all in the pclk domain.

---
 rtl/uart_link_ctl_if.sv | 20 ++
 rtl/uart_link_ctl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_link_ctl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_link_ctl_if.sv
// ---------------------------------------------------------------------------
// uart_link_if
// Byte-level handshake between the link controller and the UART tx/rx core.
//   tx_start  1-cycle send request (controller -> core)
//   tx_data   byte to send, valid while tx_start=1 (controller -> core)
//   tx_busy   transmitter busy (core -> controller)
//   rx_valid  1-cycle pulse, rx_data valid (core -> controller)
//   rx_data   received byte (core -> controller)
// Modports: master = controller side, slave = UART core side.
// ---------------------------------------------------------------------------
interface uart_link_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_valid;
    logic [7:0] rx_data;

    modport master (output tx_start, tx_data, input tx_busy, rx_valid, rx_data);
    modport slave  (input tx_start, tx_data, output tx_busy, rx_valid, rx_data);
endinterface

// File: rtl/uart_link_ctl.sv
// ---------------------------------------------------------------------------
// uart_link_ctl
// Sequences the byte-UART link between the two game boards: sends START when
// PLAY is clicked, pulses uart_start once both sides are ready, then swaps
// final scores at game end. Everything runs in the pclk domain.
// Ports:
//   pclk, rst_n      clock (75 MHz) and asynchronous active-low reset
//   play_clicked     1-cycle pulse, local PLAY clicked
//   game_over        1-cycle pulse, local game finished
//   my_score[6:0]    local score, latched when the header send starts
//   link             UART core handshake (uart_link_if.master)
//   uart_start       1-cycle pulse, both players ready
//   op_score[6:0]    opponent score, held until the next valid score
//   op_score_valid   high while in DONE
//   link_err         high while in ERR
//   state_dbg[2:0]   main FSM encoding (ERR reads as 7 with link_err=1)
// ---------------------------------------------------------------------------
module uart_link_ctl #(
    parameter int unsigned TIMEOUT_CYC = 75_000_000,
    parameter int unsigned RETRY_MAX   = 3,
    parameter logic [7:0]  START_BYTE  = 8'hA5,
    parameter logic [7:0]  SCORE_HDR   = 8'h5A
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        play_clicked,
    input  logic        game_over,
    input  logic [6:0]  my_score,
    uart_link_if.master link,
    output logic        uart_start,
    output logic [6:0]  op_score,
    output logic        op_score_valid,
    output logic        link_err,
    output logic [2:0]  state_dbg
);

    localparam int RW = $clog2(RETRY_MAX + 1) + 1;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SEND_START = 4'd1,
        WAIT_PEER  = 4'd2,
        GAME       = 4'd3,
        SEND_HDR   = 4'd4,
        SEND_SCORE = 4'd5,
        WAIT_SCORE = 4'd6,
        DONE       = 4'd7,
        ERR        = 4'd8
    } state_t;

    typedef enum logic { P_IDLE, P_SCORE } pstate_t;

    state_t          state, state_nxt;
    pstate_t         p_state;
    logic [31:0]     timer;
    logic [RW-1:0]   retries;
    logic [6:0]      score_q;
    logic            peer_ready, peer_score;
    logic            tx_hold;          // tx_start was issued last cycle
    logic            tx_ready;
    logic            tx_go;
    logic [7:0]      tx_byte;
    logic            load_timer, retry_inc, retry_clr, ready_hit, latch_score;
    logic            waiting;

    // The core raises tx_busy one cycle late, so the cycle after a request
    // is never a legal send slot regardless of what tx_busy says.
    assign tx_ready = !link.tx_busy && !tx_hold;
    assign waiting  = (state == WAIT_PEER) || (state == WAIT_SCORE);

    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        tx_go       = 1'b0;
        tx_byte     = 8'h00;
        load_timer  = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
        ready_hit   = 1'b0;
        latch_score = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (play_clicked) begin
                    state_nxt = SEND_START;
                    retry_clr = 1'b1;
                end
            end
            SEND_START: begin
                if (tx_ready) begin
                    tx_go      = 1'b1;
                    tx_byte    = START_BYTE;
                    load_timer = 1'b1;
                    state_nxt  = WAIT_PEER;
                end
            end
            WAIT_PEER: begin
                if (peer_ready) begin
                    ready_hit = 1'b1;
                    state_nxt = GAME;
                end else if (timer == 32'd0) begin
                    if (retries == RW'(RETRY_MAX)) begin
                        state_nxt = ERR;
                    end else begin
                        retry_inc = 1'b1;
                        state_nxt = SEND_START;
                    end
                end
            end
            GAME: begin
                if (game_over) begin
                    latch_score = 1'b1;
                    state_nxt   = SEND_HDR;
                end
            end
            SEND_HDR: begin
                if (tx_ready) begin
                    tx_go     = 1'b1;
                    tx_byte   = SCORE_HDR;
                    state_nxt = SEND_SCORE;
                end
            end
            SEND_SCORE: begin
                if (tx_ready) begin
                    tx_go      = 1'b1;
                    tx_byte    = {1'b0, score_q};
                    load_timer = 1'b1;
                    state_nxt  = WAIT_SCORE;
                end
            end
            WAIT_SCORE: begin
                if (peer_score) begin
                    state_nxt = DONE;
                end else if (timer == 32'd0) begin
                    state_nxt = ERR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign link.tx_start = tx_go;
    assign link.tx_data  = tx_byte;

    assign op_score_valid = (state == DONE);
    assign link_err       = (state == ERR);
    assign state_dbg      = (state == ERR) ? 3'd7 : state[2:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values and block order cannot matter.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= 32'd0;
            retries    <= '0;
            score_q    <= 7'd0;
            uart_start <= 1'b0;
            tx_hold    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx_hold    <= tx_go;
            uart_start <= ready_hit;
            if (latch_score) score_q <= my_score;
            if (retry_clr)      retries <= '0;
            else if (retry_inc) retries <= retries + RW'(1);
            if (load_timer)                   timer <= TIMEOUT_CYC;
            else if (waiting && timer != 0)   timer <= timer - 32'd1;
        end
    end

    // Rx parser, active in every main state; flags keep early arrivals.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            p_state    <= P_IDLE;
            peer_ready <= 1'b0;
            peer_score <= 1'b0;
            op_score   <= 7'd0;
        end else begin
            if (ready_hit) begin
                peer_ready <= 1'b0;
                peer_score <= 1'b0;
            end
            // NOTE: the rx set is written after the clear above; the last
            // non-blocking assignment wins, so a same-cycle set survives.
            if (link.rx_valid) begin
                case (p_state)
                    P_IDLE: begin
                        if (link.rx_data == START_BYTE)     peer_ready <= 1'b1;
                        else if (link.rx_data == SCORE_HDR) p_state    <= P_SCORE;
                    end
                    P_SCORE: begin
                        if (!link.rx_data[7]) begin
                            op_score   <= link.rx_data[6:0];
                            peer_score <= 1'b1;
                        end
                        p_state <= P_IDLE;
                    end
                    default: p_state <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_link_ctl.sv
// ---------------------------------------------------------------------------
// tb_uart_link_ctl
// Directed bench for uart_link_ctl with TIMEOUT_CYC=100, RETRY_MAX=3. A small
// UART core model answers tx_start with tx_busy (one cycle late, then
// BUSY_LEN cycles high) and logs every byte with its cycle number.
// ---------------------------------------------------------------------------
module tb_uart_link_ctl;

    localparam int unsigned TIMEOUT_CYC = 100;
    localparam int unsigned RETRY_MAX   = 3;
    localparam int          BUSY_LEN    = 10;

    logic       pclk = 1'b0;
    logic       rst_n;
    logic       play_clicked;
    logic       game_over;
    logic [6:0] my_score;
    logic       uart_start;
    logic [6:0] op_score;
    logic       op_score_valid;
    logic       link_err;
    logic [2:0] state_dbg;

    uart_link_if lnk();

    uart_link_ctl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .RETRY_MAX   (RETRY_MAX),
        .START_BYTE  (8'hA5),
        .SCORE_HDR   (8'h5A)
    ) dut (
        .pclk           (pclk),
        .rst_n          (rst_n),
        .play_clicked   (play_clicked),
        .game_over      (game_over),
        .my_score       (my_score),
        .link           (lnk),
        .uart_start     (uart_start),
        .op_score       (op_score),
        .op_score_valid (op_score_valid),
        .link_err       (link_err),
        .state_dbg      (state_dbg)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    int         ustart_cnt  = 0;
    int         ustart_cyc  = 0;
    int         overlap_cnt = 0;
    int         last_rx_cyc = 0;

    // UART core model: samples requests at the falling edge, raises tx_busy
    // one cycle after the request and holds it for BUSY_LEN cycles.
    initial begin : uart_model
        int busy_left;
        bit fire;
        bit pend;
        busy_left   = 0;
        pend        = 1'b0;
        lnk.tx_busy = 1'b0;
        forever begin
            @(negedge pclk);
            fire = (lnk.tx_start === 1'b1);
            if (fire) begin
                tx_log.push_back(lnk.tx_data);
                tx_cyc.push_back(cyc);
                if (lnk.tx_busy || pend) overlap_cnt++;
            end
            if (uart_start === 1'b1) begin
                ustart_cnt++;
                ustart_cyc = cyc;
            end
            @(posedge pclk);
            #1;
            if (pend) begin
                pend        = 1'b0;
                busy_left   = BUSY_LEN;
                lnk.tx_busy = 1'b1;
            end else if (busy_left > 0) begin
                busy_left--;
                lnk.tx_busy = (busy_left > 0);
            end
            if (fire) pend = 1'b1;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic pulse_play();
        @(posedge pclk); #1;
        play_clicked = 1'b1;
        @(posedge pclk); #1;
        play_clicked = 1'b0;
    endtask

    task automatic pulse_game_over();
        @(posedge pclk); #1;
        game_over = 1'b1;
        @(posedge pclk); #1;
        game_over = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(posedge pclk); #1;
        lnk.rx_valid = 1'b1;
        lnk.rx_data  = b;
        last_rx_cyc  = cyc;
        @(posedge pclk); #1;
        lnk.rx_valid = 1'b0;
        lnk.rx_data  = 8'h00;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge pclk);
            if (state_dbg === s) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        n_checks++;
        if (state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, expected 0", state_dbg);
        end
        n_checks++;
        if ({uart_start, op_score, op_score_valid, link_err, lnk.tx_start, lnk.tx_data} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got us=%0b op=%0d v=%0b err=%0b ts=%0b td=%0h, expected all 0",
                     uart_start, op_score, op_score_valid, link_err, lnk.tx_start, lnk.tx_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_handshake();
        int base, ubase;
        base  = tx_log.size();
        ubase = ustart_cnt;
        pulse_play();
        step(45);
        rx_byte(8'hA5);
        repeat (5) @(negedge pclk);
        n_checks++;
        if (tx_log.size() - base !== 1) begin
            n_fail++;
            $display("FAIL hs_tx_count: got %0d, expected 1", tx_log.size() - base);
        end else begin
            n_checks++;
            if (tx_log[base] !== 8'hA5) begin
                n_fail++;
                $display("FAIL hs_tx_byte: got %0h, expected a5", tx_log[base]);
            end
        end
        n_checks++;
        if (ustart_cnt - ubase !== 1) begin
            n_fail++;
            $display("FAIL hs_uart_start_count: got %0d, expected 1", ustart_cnt - ubase);
        end
        // rx sampled one edge after last_rx_cyc, flag seen the edge after
        n_checks++;
        if (ustart_cyc !== last_rx_cyc + 2) begin
            n_fail++;
            $display("FAIL hs_uart_start_latency: got cycle %0d, expected %0d", ustart_cyc, last_rx_cyc + 2);
        end
        n_checks++;
        if (state_dbg !== 3'd3) begin
            n_fail++;
            $display("FAIL hs_state_game: got %0d, expected 3", state_dbg);
        end
    endtask

    task automatic test_early_start();
        int base, ubase;
        do_reset();
        base  = tx_log.size();
        ubase = ustart_cnt;
        step(4);
        rx_byte(8'hA5);
        step(14);
        pulse_play();
        repeat (6) @(negedge pclk);
        n_checks++;
        if (tx_log.size() - base !== 1) begin
            n_fail++;
            $display("FAIL early_tx_count: got %0d, expected 1", tx_log.size() - base);
        end else begin
            n_checks++;
            if (tx_log[base] !== 8'hA5) begin
                n_fail++;
                $display("FAIL early_tx_byte: got %0h, expected a5", tx_log[base]);
            end
            // tx in SEND_START, WAIT_PEER next cycle, uart_start one later
            n_checks++;
            if (ustart_cnt - ubase !== 1 || ustart_cyc !== tx_cyc[base] + 2) begin
                n_fail++;
                $display("FAIL early_uart_start: got count %0d at cycle %0d, expected 1 at %0d",
                         ustart_cnt - ubase, ustart_cyc, tx_cyc[base] + 2);
            end
        end
        n_checks++;
        if (state_dbg !== 3'd3) begin
            n_fail++;
            $display("FAIL early_state_game: got %0d, expected 3", state_dbg);
        end
    endtask

    task automatic test_retry_timeout();
        int  base, ubase;
        bit  ok;
        do_reset();
        base  = tx_log.size();
        ubase = ustart_cnt;
        pulse_play();
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge pclk);
            if (link_err === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL retry_link_err: got 0 after 600 cycles, expected 1");
        end
        n_checks++;
        if (tx_log.size() - base !== 4) begin
            n_fail++;
            $display("FAIL retry_tx_count: got %0d, expected 4", tx_log.size() - base);
        end else begin
            // TIMEOUT_CYC+1 cycles in WAIT_PEER plus one in SEND_START
            for (int i = 1; i < 4; i++) begin
                n_checks++;
                if (tx_log[base + i] !== 8'hA5 || tx_cyc[base + i] - tx_cyc[base + i - 1] !== 102) begin
                    n_fail++;
                    $display("FAIL retry_spacing_%0d: got byte %0h gap %0d, expected a5 gap 102",
                             i, tx_log[base + i], tx_cyc[base + i] - tx_cyc[base + i - 1]);
                end
            end
        end
        n_checks++;
        if (state_dbg !== 3'd7 || op_score_valid !== 1'b0 || ustart_cnt !== ubase) begin
            n_fail++;
            $display("FAIL retry_err_state: got state %0d valid %0b ustart %0d, expected 7 0 0",
                     state_dbg, op_score_valid, ustart_cnt - ubase);
        end
        pulse_play();
        repeat (3) @(negedge pclk);
        n_checks++;
        if (link_err !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_err_clear: got %0b, expected 0", link_err);
        end
        n_checks++;
        if (tx_log.size() - base !== 5 || tx_log[tx_log.size() - 1] !== 8'hA5) begin
            n_fail++;
            $display("FAIL retry_restart_tx: got count %0d, expected 5 with a5", tx_log.size() - base);
        end
    endtask

    task automatic test_score_exchange();
        int base;
        bit ok;
        rx_byte(8'hA5);
        wait_state(3'd3, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL score_reach_game: got state %0d, expected 3", state_dbg);
        end
        base     = tx_log.size();
        my_score = 7'd42;
        pulse_game_over();
        rx_byte(8'h5A);
        rx_byte(8'h17);
        wait_state(3'd7, 200, ok);
        n_checks++;
        if (!ok || link_err !== 1'b0) begin
            n_fail++;
            $display("FAIL score_done: got state %0d err %0b, expected 7 0", state_dbg, link_err);
        end
        n_checks++;
        if (tx_log.size() - base !== 2) begin
            n_fail++;
            $display("FAIL score_tx_count: got %0d, expected 2", tx_log.size() - base);
        end else begin
            n_checks++;
            if (tx_log[base] !== 8'h5A || tx_log[base + 1] !== 8'h2A) begin
                n_fail++;
                $display("FAIL score_tx_bytes: got %0h %0h, expected 5a 2a", tx_log[base], tx_log[base + 1]);
            end
            // one latency cycle plus BUSY_LEN busy cycles before the next slot
            n_checks++;
            if (tx_cyc[base + 1] - tx_cyc[base] !== BUSY_LEN + 2) begin
                n_fail++;
                $display("FAIL score_back_to_back: got gap %0d, expected %0d",
                         tx_cyc[base + 1] - tx_cyc[base], BUSY_LEN + 2);
            end
        end
        n_checks++;
        if (op_score !== 7'd23 || op_score_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL score_op_score: got %0d valid %0b, expected 23 1", op_score, op_score_valid);
        end
    endtask

    task automatic test_score_filter();
        int base;
        int done_cyc;
        bit ok;
        pulse_play();
        step(3);
        rx_byte(8'hA5);
        wait_state(3'd3, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL filter_reach_game: got state %0d, expected 3", state_dbg);
        end
        rx_byte(8'h5A);
        rx_byte(8'hF0);
        step(2);
        n_checks++;
        if (op_score !== 7'd23) begin
            n_fail++;
            $display("FAIL filter_discard: got %0d, expected 23", op_score);
        end
        rx_byte(8'h5A);
        rx_byte(8'h09);
        step(2);
        n_checks++;
        if (op_score !== 7'd9 || op_score_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL filter_second_pair: got %0d valid %0b, expected 9 0", op_score, op_score_valid);
        end
        base     = tx_log.size();
        my_score = 7'd5;
        pulse_game_over();
        wait_state(3'd7, 100, ok);
        done_cyc = cyc;
        n_checks++;
        if (!ok || tx_log.size() - base !== 2) begin
            n_fail++;
            $display("FAIL filter_done: got state %0d tx %0d, expected 7 2", state_dbg, tx_log.size() - base);
        end else begin
            n_checks++;
            if (tx_log[base] !== 8'h5A || tx_log[base + 1] !== 8'h05) begin
                n_fail++;
                $display("FAIL filter_tx_bytes: got %0h %0h, expected 5a 05", tx_log[base], tx_log[base + 1]);
            end
            // score already flagged: WAIT_SCORE lasts one cycle
            n_checks++;
            if (done_cyc - tx_cyc[base + 1] !== 2) begin
                n_fail++;
                $display("FAIL filter_done_latency: got %0d, expected 2", done_cyc - tx_cyc[base + 1]);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        pulse_play();
        step(3);
        rx_byte(8'hA5);
        wait_state(3'd3, 20, ok);
        my_score = 7'd7;
        pulse_game_over();
        wait_state(3'd6, 100, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midop_reach_wait_score: got state %0d, expected 6", state_dbg);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== 3'd0) begin
            n_fail++;
            $display("FAIL midop_state: got %0d, expected 0", state_dbg);
        end
        n_checks++;
        if ({uart_start, op_score, op_score_valid, link_err, lnk.tx_start, lnk.tx_data} !== 19'd0) begin
            n_fail++;
            $display("FAIL midop_outputs: got us=%0b op=%0d v=%0b err=%0b ts=%0b td=%0h, expected all 0",
                     uart_start, op_score, op_score_valid, link_err, lnk.tx_start, lnk.tx_data);
        end
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        rst_n        = 1'b0;
        play_clicked = 1'b0;
        game_over    = 1'b0;
        my_score     = 7'd0;
        lnk.rx_valid = 1'b0;
        lnk.rx_data  = 8'h00;

        test_reset();
        test_handshake();
        test_early_start();
        test_retry_timeout();
        test_score_exchange();
        test_score_filter();
        test_reset_midop();

        n_checks++;
        if (overlap_cnt !== 0) begin
            n_fail++;
            $display("FAIL tx_overlap: got %0d overlapping requests, expected 0", overlap_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
